// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit bus CPU: control-bit indices, opcodes,
// microstep stages and control-word width.
package cpu_pkg;

  localparam int CTRL_W = 16;

  // Control-word bit positions
  localparam int AI = 0;
  localparam int AO = 1;
  localparam int BI = 2;
  localparam int BO = 3;
  localparam int II = 4;
  localparam int IO = 5;
  localparam int OI = 6;
  localparam int OO = 7;
  localparam int RI = 8;
  localparam int RO = 9;
  localparam int J  = 10;
  localparam int CO = 11;
  localparam int CE = 12;
  localparam int EO = 13;
  localparam int SU = 14;
  localparam int FI = 15;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } stage_t;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int unsigned idx);
    ctrl_bit = {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Run/step/opcode/flag inputs and control-word/status outputs of the sequencer.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic              i_run;
  logic              i_step;
  logic [3:0]        i_opcode;
  logic              i_carry;
  logic              i_zero;
  logic [CTRL_W-1:0] o_ctrl;
  logic [2:0]        o_stage;
  logic              o_halted;
  logic              o_illegal;

  modport master (
    output i_run, i_step, i_opcode, i_carry, i_zero,
    input  o_ctrl, o_stage, o_halted, o_illegal
  );

  modport slave (
    input  i_run, i_step, i_opcode, i_carry, i_zero,
    output o_ctrl, o_stage, o_halted, o_illegal
  );

endinterface

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode lookup: (stage, opcode, flags) -> control word plus
// end-of-instruction, illegal-opcode and halt indications.
module microcode_rom
  import cpu_pkg::*;
(
  input  stage_t            stage,
  input  logic [3:0]        opcode,
  input  logic              carry,
  input  logic              zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last,
  output logic              illegal,
  output logic              halt
);

  // Microcode table; fetch stages ignore the opcode
  always_comb begin
    ctrl    = {CTRL_W{1'b0}};
    last    = 1'b0;
    illegal = 1'b0;
    halt    = 1'b0;
    case (stage)
      T0: ctrl = ctrl_bit(CO) | ctrl_bit(RI);
      T1: ctrl = ctrl_bit(RO) | ctrl_bit(II);
      T2: ctrl = ctrl_bit(CE);
      T3: begin
        case (opcode)
          OP_NOP: last = 1'b1;
          OP_LDA, OP_ADD, OP_SUB: ctrl = ctrl_bit(IO) | ctrl_bit(RI);
          OP_LDI: begin
            ctrl = ctrl_bit(IO) | ctrl_bit(AI);
            last = 1'b1;
          end
          OP_JMP: begin
            ctrl = ctrl_bit(IO) | ctrl_bit(J);
            last = 1'b1;
          end
          OP_JC: begin
            if (carry) ctrl = ctrl_bit(IO) | ctrl_bit(J);
            else       ctrl = {CTRL_W{1'b0}};
            last = 1'b1;
          end
          OP_JZ: begin
            if (zero) ctrl = ctrl_bit(IO) | ctrl_bit(J);
            else      ctrl = {CTRL_W{1'b0}};
            last = 1'b1;
          end
          OP_OUT: begin
            ctrl = ctrl_bit(AO) | ctrl_bit(OI);
            last = 1'b1;
          end
          OP_HLT: begin
            halt = 1'b1;
            last = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            last    = 1'b1;
          end
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            ctrl = ctrl_bit(RO) | ctrl_bit(AI);
            last = 1'b1;
          end
          OP_ADD, OP_SUB: ctrl = ctrl_bit(RO) | ctrl_bit(BI);
          default: last = 1'b1;
        endcase
      end
      T5: begin
        case (opcode)
          OP_ADD: ctrl = ctrl_bit(EO) | ctrl_bit(AI) | ctrl_bit(FI);
          OP_SUB: ctrl = ctrl_bit(EO) | ctrl_bit(AI) | ctrl_bit(SU) | ctrl_bit(FI);
          default: ctrl = {CTRL_W{1'b0}};
        endcase
        last = 1'b1;
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-stage counter, opcode latch, halt latch and the
// run/step advance enable; decoding is delegated to microcode_rom.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_STAGES = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  control_sequencer_if.slave  bus
);

  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

  stage_t            stage_r, stage_next_s;
  logic [3:0]        opcode_r, opcode_next_s;
  logic              halted_r, halted_next_s;
  logic              adv_s;
  logic [CTRL_W-1:0] rom_ctrl_s;
  logic              rom_last_s;
  logic              rom_illegal_s;
  logic              rom_halt_s;

  assign adv_s = ~halted_r & (bus.i_run | bus.i_step);

  microcode_rom u_rom (
    .stage   (stage_r),
    .opcode  (opcode_r),
    .carry   (bus.i_carry),
    .zero    (bus.i_zero),
    .ctrl    (rom_ctrl_s),
    .last    (rom_last_s),
    .illegal (rom_illegal_s),
    .halt    (rom_halt_s)
  );

  // Next-state logic: everything holds unless the sequencer advances
  always_comb begin
    stage_next_s  = stage_r;
    opcode_next_s = opcode_r;
    halted_next_s = halted_r;
    if (adv_s) begin
      if (rom_last_s || (stage_r == LAST_STAGE)) stage_next_s = T0;
      else                                       stage_next_s = stage_t'(stage_r + 3'd1);
      if (stage_r == T1) opcode_next_s = bus.i_opcode;
      else               opcode_next_s = opcode_r;
      if (rom_halt_s) halted_next_s = 1'b1;
      else            halted_next_s = halted_r;
    end else begin
      stage_next_s  = stage_r;
      opcode_next_s = opcode_r;
      halted_next_s = halted_r;
    end
  end

  // State registers; reset abandons any instruction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_r  <= T0;
      opcode_r <= 4'd0;
      halted_r <= 1'b0;
    end else begin
      stage_r  <= stage_next_s;
      opcode_r <= opcode_next_s;
      halted_r <= halted_next_s;
    end
  end

  assign bus.o_ctrl    = halted_r ? {CTRL_W{1'b0}} : rom_ctrl_s;
  assign bus.o_stage   = stage_r;
  assign bus.o_halted  = halted_r;
  assign bus.o_illegal = rom_illegal_s & adv_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-cycle outputs, a monitor
// on the falling edge pops and compares them.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_sequencer_if ifc();

  control_sequencer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc.slave)
  );

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [15:0] ctrl;
    logic        h;
    logic        il;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Monitor: every cycle with a queued expectation is checked mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests += 4;
      if (ifc.o_stage !== e.st) begin
        fails++;
        $display("FAIL %s stage: got %0d want %0d", e.name, ifc.o_stage, e.st);
      end
      if (ifc.o_ctrl !== e.ctrl) begin
        fails++;
        $display("FAIL %s ctrl: got %04h want %04h", e.name, ifc.o_ctrl, e.ctrl);
      end
      if (ifc.o_halted !== e.h) begin
        fails++;
        $display("FAIL %s halted: got %0b want %0b", e.name, ifc.o_halted, e.h);
      end
      if (ifc.o_illegal !== e.il) begin
        fails++;
        $display("FAIL %s illegal: got %0b want %0b", e.name, ifc.o_illegal, e.il);
      end
    end
  end

  task automatic cyc(input string name, input logic r, input logic run, input logic step,
                     input logic [3:0] op, input logic c, input logic z,
                     input logic [2:0] st, input logic [15:0] ctrl,
                     input logic h, input logic il);
    exp_t e;
    rst          = r;
    ifc.i_run    = run;
    ifc.i_step   = step;
    ifc.i_opcode = op;
    ifc.i_carry  = c;
    ifc.i_zero   = z;
    e.name = name; e.st = st; e.ctrl = ctrl; e.h = h; e.il = il;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ifc.i_run  = 1'b0;
    ifc.i_step = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset followed by the three fetch microsteps in free-run
  task automatic fetch(input string name, input logic [3:0] op, input logic c, input logic z);
    do_reset();
    cyc({name, "_t0"}, 1'b0, 1'b1, 1'b0, op, c, z, 3'd0, 16'h0900, 1'b0, 1'b0);
    cyc({name, "_t1"}, 1'b0, 1'b1, 1'b0, op, c, z, 3'd1, 16'h0210, 1'b0, 1'b0);
    cyc({name, "_t2"}, 1'b0, 1'b1, 1'b0, op, c, z, 3'd2, 16'h1000, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.i_run = 1'b0; ifc.i_step = 1'b0; ifc.i_opcode = 4'd0;
    ifc.i_carry = 1'b0; ifc.i_zero = 1'b0;

    do_reset();
    cyc("reset", 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);

    // ADD; opcode input changes after T1 to prove the latch holds
    fetch("add", 4'h2, 1'b0, 1'b0);
    cyc("add_t3", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd3, 16'h0120, 1'b0, 1'b0);
    cyc("add_t4", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd4, 16'h0204, 1'b0, 1'b0);
    cyc("add_t5", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd5, 16'hA001, 1'b0, 1'b0);
    cyc("add_wrap", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);

    fetch("sub", 4'h3, 1'b0, 1'b0);
    cyc("sub_t3", 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 3'd3, 16'h0120, 1'b0, 1'b0);
    cyc("sub_t4", 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 3'd4, 16'h0204, 1'b0, 1'b0);
    cyc("sub_t5", 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 3'd5, 16'hE001, 1'b0, 1'b0);

    fetch("jc0", 4'h7, 1'b0, 1'b1);
    cyc("jc0_t3", 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0);
    cyc("jc0_next", 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 3'd0, 16'h0900, 1'b0, 1'b0);
    fetch("jc1", 4'h7, 1'b1, 1'b0);
    cyc("jc1_t3", 1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 3'd3, 16'h0420, 1'b0, 1'b0);
    cyc("jc1_next", 1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);

    fetch("jz1", 4'h8, 1'b0, 1'b1);
    cyc("jz1_t3", 1'b0, 1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 3'd3, 16'h0420, 1'b0, 1'b0);
    fetch("jz0", 4'h8, 1'b1, 1'b0);
    cyc("jz0_t3", 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0);

    fetch("jmp", 4'h6, 1'b0, 1'b0);
    cyc("jmp_t3", 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 3'd3, 16'h0420, 1'b0, 1'b0);
    fetch("ldi", 4'h5, 1'b0, 1'b0);
    cyc("ldi_t3", 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 3'd3, 16'h0021, 1'b0, 1'b0);
    cyc("ldi_next", 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);
    fetch("out", 4'hE, 1'b0, 1'b0);
    cyc("out_t3", 1'b0, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 3'd3, 16'h0042, 1'b0, 1'b0);
    fetch("nop", 4'h0, 1'b0, 1'b0);
    cyc("nop_t3", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0);
    cyc("nop_next", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);

    // Single-step: advance only on pulse cycles
    do_reset();
    cyc("step_idle0", 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);
    cyc("step_p1", 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);
    cyc("step_idle1a", 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 3'd1, 16'h0210, 1'b0, 1'b0);
    cyc("step_idle1b", 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 3'd1, 16'h0210, 1'b0, 1'b0);
    cyc("step_p2", 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 3'd1, 16'h0210, 1'b0, 1'b0);
    cyc("step_idle2", 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 3'd2, 16'h1000, 1'b0, 1'b0);
    cyc("step_p3", 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 3'd2, 16'h1000, 1'b0, 1'b0);
    cyc("step_idle3", 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 3'd3, 16'h0120, 1'b0, 1'b0);

    // HLT freezes everything until reset
    fetch("hlt", 4'hF, 1'b0, 1'b0);
    cyc("hlt_t3", 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0);
    cyc("hlt_a", 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    cyc("hlt_b", 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    cyc("hlt_c", 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    cyc("hlt_rst", 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);

    fetch("ill", 4'hA, 1'b0, 1'b0);
    cyc("ill_t3", 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b1);
    cyc("ill_next", 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);
    fetch("ill4", 4'h4, 1'b0, 1'b0);
    cyc("ill4_t3", 1'b0, 1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b1);

    // Reset at T4 of LDA
    fetch("lda", 4'h1, 1'b0, 1'b0);
    cyc("lda_t3", 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 3'd3, 16'h0120, 1'b0, 1'b0);
    cyc("lda_t4", 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 3'd4, 16'h0201, 1'b0, 1'b0);
    cyc("lda_rst", 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 3'd0, 16'h0900, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit bus CPU.
- Steps the T-stage counter and decodes the latched opcode, stage and ALU flags into the 16-bit control word that drives register, PC, memory and ALU enables.
- Adds run/single-step control, conditional jumps (JC, JZ), a flags-in strobe, halt, and illegal-opcode reporting.
- Replaces the inline FSM inside cpu; cpu instantiates it and wires o_ctrl to the datapath.

Parameters:
- NUM_STAGES, 6, number of microstep slots T0..T(NUM_STAGES-1); fixed at 6 for this ISA.
- CTRL_W, 16, control word width.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_run  input  1  1 = free-run, advance one microstep per clock
- i_step  input  1  single-cycle pulse; advances one microstep when i_run=0
- i_opcode  input  4  instruction register [7:4]; sampled at end of T1
- i_carry  input  1  flags register carry bit
- i_zero  input  1  flags register zero bit
- o_ctrl  output  CTRL_W  control word: AI0 AO1 BI2 BO3 II4 IO5 OI6 OO7 RI8 RO9 J10 CO11 CE12 EO13 SU14 FI15
- o_stage  output  3  current T-stage
- o_halted  output  1  HLT executed
- o_illegal  output  1  one-cycle pulse on an unknown opcode at T3

Behaviour:
- Reset: stage=T0, opcode latch=0, halted=0, illegal=0. o_ctrl then shows the T0 word (CO|RI).
- Advance enable: adv = ~halted & (i_run | i_step). When adv=0, stage and latches hold and o_ctrl stays stable.
- o_ctrl is combinational from (stage, latched opcode, i_carry, i_zero). It is 0 while halted.
- Fetch, all opcodes:
  - T0: CO|RI
  - T1: RO|II; opcode latch <= i_opcode on an advancing edge in T1
  - T2: CE
- Execute, T3 onward:
  - NOP 0000: T3 none, return.
  - LDA 0001: T3 IO|RI; T4 RO|AI.
  - ADD 0010: T3 IO|RI; T4 RO|BI; T5 EO|AI|FI.
  - SUB 0011: T3 IO|RI; T4 RO|BI; T5 EO|AI|SU|FI.
  - LDI 0101: T3 IO|AI.
  - JMP 0110: T3 IO|J.
  - JC 0111: T3 IO|J if i_carry, else 0.
  - JZ 1000: T3 IO|J if i_zero, else 0.
  - OUT 1110: T3 AO|OI.
  - HLT 1111: T3 0; halted <= 1 on the advancing edge.
- Early termination: the step after an opcode's last microstep is T0. No empty slots are executed. After T5 the stage always wraps to T0.
- Unknown opcodes (0100, 1001-1101): T3 o_ctrl=0, o_illegal=1 for that advancing cycle, next stage T0.
- Flags for JC/JZ are sampled combinationally during T3. The flags register updates only on FI.
- halted is cleared only by i_rst. i_run and i_step are ignored while halted.
- i_rst mid-instruction: next cycle stage=T0 and all microstep state is abandoned. i_rst has priority over adv.
- i_step held for several cycles advances once per cycle; edge detection is the debouncer's job.

Decomposition:
- Package cpu_pkg holds:
  - control-bit index constants AI..FI
  - opcode constants OP_NOP..OP_HLT, including OP_JC and OP_JZ
  - stage constants T0..T5
  - CTRL_W
- One natural sub-module: microcode_rom, a combinational (stage, opcode, carry, zero) -> {ctrl, last, illegal} lookup. control_sequencer keeps only the stage counter, latches and enable logic.

Test Plan:
- Reset, i_run=1, opcode=0010 (ADD): o_ctrl sequence 0x0900, 0x0210, 0x1000, 0x0120, 0x0204, 0xA001, then T0 again. o_stage walks 0,1,2,3,4,5,0.
- opcode=0111 (JC), i_carry=0 -> T3 o_ctrl=0x0000, next stage 0. Repeat with i_carry=1 -> T3 o_ctrl=0x0420.
- i_run=0, pulse i_step three times with gaps -> o_stage 0->1->2->3 only on pulse cycles; o_ctrl constant between pulses.
- opcode=1111 (HLT) -> o_halted=1 after T3, o_ctrl=0 afterwards, stage frozen despite i_run=1. i_rst=1 for one cycle -> o_halted=0, o_stage=0.
- opcode=1010 -> o_illegal high exactly one cycle at T3, o_ctrl=0, next stage 0.
- i_rst asserted at T4 of LDA -> next cycle o_stage=0, o_ctrl=0x0900.
